led_blink_ctrl: RTL and testbench

//  Parametrised memory-mapped LED controller on the memorio bus, driving NUM_LEDS board LEDs.

---
 rtl/led_blink_ctrl.sv | 146 ++++++++++++++
 tb/tb_led_blink_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: memory-mapped LED controller on the memorio bus.
// Registers: DATA (0), BLINK_MASK (1), BLINK_DIV (2), TOGGLE (3).
// All state updates on the falling edge of led_clk.
// ledrst clears every register asynchronously.
// Masked LEDs blink with a half-period of BLINK_DIV cycles.
// ledrst_ind stays lit until software first writes DATA or TOGGLE.
module led_blink_ctrl #(
  parameter int NUM_LEDS = 16,
  parameter int DIV_W    = 24,
  parameter logic [DIV_W-1:0] DIV_RESET = {DIV_W{1'b0}}
) (
  input  logic                led_clk,
  input  logic                ledrst,
  input  logic                ledcs,
  input  logic                ledwrite,
  input  logic                ledread,
  input  logic [1:0]          ledaddr,
  input  logic [31:0]         ledwdata,
  output logic [31:0]         ledrdata,
  output logic [NUM_LEDS-1:0] ledout,
  output logic                ledrst_ind
);

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);

  // Architectural registers
  logic [NUM_LEDS-1:0] data_r;
  logic [NUM_LEDS-1:0] mask_r;
  logic [DIV_W-1:0]    div_r;
  logic [DIV_W-1:0]    cnt_r;
  logic                phase_r;
  logic [31:0]         rdata_r;
  logic                ind_r;

  // Next-state values
  logic [NUM_LEDS-1:0] data_nxt_s;
  logic [NUM_LEDS-1:0] mask_nxt_s;
  logic [DIV_W-1:0]    div_nxt_s;
  logic [DIV_W-1:0]    cnt_nxt_s;
  logic                phase_nxt_s;
  logic [31:0]         rdata_nxt_s;
  logic                ind_nxt_s;

  // Bus decode
  logic                wr_s;
  logic                rd_s;
  logic                div_wr_s;
  logic [NUM_LEDS-1:0] wled_s;
  logic [DIV_W-1:0]    wdiv_s;
  logic [NUM_LEDS-1:0] led_s;
  logic                wdata_unused_s;

  // A write takes priority over a read issued in the same cycle.
  assign wr_s     = ledcs & ledwrite;
  assign rd_s     = ledcs & ledread & ~ledwrite;
  assign div_wr_s = wr_s & (ledaddr == 2'd2);
  assign wled_s   = ledwdata[NUM_LEDS-1:0];
  assign wdiv_s   = ledwdata[DIV_W-1:0];

  // Bits above the register width carry no meaning.
  assign wdata_unused_s = ^ledwdata;

  // A masked LED is lit only during the "on" half of the blink.
  assign led_s  = data_r & (~mask_r | {NUM_LEDS{phase_r}});
  assign ledout = led_s;

  assign ledrdata   = rdata_r;
  assign ledrst_ind = ind_r;

  // Register file writes, read-data capture and the reset indicator.
  always_comb begin
    data_nxt_s  = data_r;
    mask_nxt_s  = mask_r;
    div_nxt_s   = div_r;
    rdata_nxt_s = rdata_r;
    ind_nxt_s   = ind_r;
    if (wr_s) begin
      case (ledaddr)
        2'd0: begin
          data_nxt_s = wled_s;
          ind_nxt_s  = 1'b0;
        end
        2'd1: mask_nxt_s = wled_s;
        2'd2: div_nxt_s  = wdiv_s;
        2'd3: begin
          data_nxt_s = data_r ^ wled_s;
          ind_nxt_s  = 1'b0;
        end
        default: data_nxt_s = data_r;
      endcase
    end else if (rd_s) begin
      case (ledaddr)
        2'd0:    rdata_nxt_s = 32'(data_r);
        2'd1:    rdata_nxt_s = 32'(mask_r);
        2'd2:    rdata_nxt_s = 32'(div_r);
        2'd3:    rdata_nxt_s = 32'(led_s);
        default: rdata_nxt_s = rdata_r;
      endcase
    end else begin
      rdata_nxt_s = rdata_r;
    end
  end

  // Blink divider: a DIV write restarts lit; div 0 freezes the phase on.
  // The >= compare lets a counter left above a smaller divider wrap at once.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    phase_nxt_s = phase_r;
    if (div_wr_s) begin
      cnt_nxt_s   = DIV_ZERO;
      phase_nxt_s = 1'b1;
    end else if (div_r == DIV_ZERO) begin
      cnt_nxt_s   = DIV_ZERO;
      phase_nxt_s = 1'b1;
    end else if (cnt_r >= (div_r - DIV_ONE)) begin
      cnt_nxt_s   = DIV_ZERO;
      phase_nxt_s = ~phase_r;
    end else begin
      cnt_nxt_s   = cnt_r + DIV_ONE;
      phase_nxt_s = phase_r;
    end
  end

  // State update on the falling clock edge with asynchronous reset.
  always_ff @(negedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      data_r  <= {NUM_LEDS{1'b0}};
      mask_r  <= {NUM_LEDS{1'b0}};
      div_r   <= DIV_RESET;
      cnt_r   <= DIV_ZERO;
      phase_r <= 1'b1;
      rdata_r <= 32'h0000_0000;
      ind_r   <= 1'b1;
    end else begin
      data_r  <= data_nxt_s;
      mask_r  <= mask_nxt_s;
      div_r   <= div_nxt_s;
      cnt_r   <= cnt_nxt_s;
      phase_r <= phase_nxt_s;
      rdata_r <= rdata_nxt_s;
      ind_r   <= ind_nxt_s;
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Testbench for led_blink_ctrl: directed vector table, hand-written blink
// sequences and randomized bus traffic against an elapsed-time reference model.
module tb_led_blink_ctrl;

  logic        clk = 1'b0;
  logic        ledrst;
  logic        ledcs;
  logic        ledwrite;
  logic        ledread;
  logic [1:0]  ledaddr;
  logic [31:0] ledwdata;
  logic [31:0] ledrdata;
  logic [15:0] ledout;
  logic        ledrst_ind;
  logic [31:0] ledrdata8;
  logic [7:0]  ledout8;
  logic        ledrst_ind8;

  int checks   = 0;
  int failures = 0;

  // Reference model state: blink phase derived from edges since last restart.
  logic [15:0] m_data;
  logic [15:0] m_mask;
  logic [31:0] m_div;
  int unsigned m_t;
  logic [31:0] m_rdata;
  logic        m_ind;

  led_blink_ctrl #(.NUM_LEDS(16), .DIV_W(24)) dut (
    .led_clk(clk), .ledrst(ledrst), .ledcs(ledcs), .ledwrite(ledwrite),
    .ledread(ledread), .ledaddr(ledaddr), .ledwdata(ledwdata),
    .ledrdata(ledrdata), .ledout(ledout), .ledrst_ind(ledrst_ind)
  );

  led_blink_ctrl #(.NUM_LEDS(8), .DIV_W(24)) dut8 (
    .led_clk(clk), .ledrst(ledrst), .ledcs(ledcs), .ledwrite(ledwrite),
    .ledread(ledread), .ledaddr(ledaddr), .ledwdata(ledwdata),
    .ledrdata(ledrdata8), .ledout(ledout8), .ledrst_ind(ledrst_ind8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [15:0] led;
    logic [31:0] rdata;
    logic        ind;
  } vec_t;

  vec_t vecs[11];

  function automatic logic m_phase();
    if (m_div == 32'd0) return 1'b1;
    return ((m_t / m_div) % 2) == 0;
  endfunction

  function automatic logic [15:0] m_led();
    return m_phase() ? m_data : (m_data & ~m_mask);
  endfunction

  task automatic m_reset();
    m_data = 16'h0; m_mask = 16'h0; m_div = 32'd0;
    m_t = 0; m_rdata = 32'h0; m_ind = 1'b1;
  endtask

  task automatic m_edge(input logic cs, input logic we, input logic re,
                        input logic [1:0] a, input logic [31:0] w);
    logic [15:0] led_pre;
    logic        restart;
    led_pre = m_led();
    restart = 1'b0;
    if (cs && we) begin
      case (a)
        2'd0: begin m_data = w[15:0]; m_ind = 1'b0; end
        2'd1: m_mask = w[15:0];
        2'd2: begin m_div = {8'h00, w[23:0]}; restart = 1'b1; end
        default: begin m_data = m_data ^ w[15:0]; m_ind = 1'b0; end
      endcase
    end else if (cs && re) begin
      case (a)
        2'd0: m_rdata = {16'h0, m_data};
        2'd1: m_rdata = {16'h0, m_mask};
        2'd2: m_rdata = m_div;
        default: m_rdata = {16'h0, led_pre};
      endcase
    end
    if (restart) m_t = 0;
    else m_t = m_t + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive after posedge, DUT and model update on negedge, compare.
  task automatic step(input logic cs, input logic we, input logic re,
                      input logic [1:0] a, input logic [31:0] w);
    @(posedge clk);
    ledcs = cs; ledwrite = we; ledread = re; ledaddr = a; ledwdata = w;
    @(negedge clk);
    m_edge(cs, we, re, a, w);
    #1;
    chk("ledout_vs_model", {16'h0, ledout}, {16'h0, m_led()});
    chk("ledrdata_vs_model", ledrdata, m_rdata);
    chk("ledrst_ind_vs_model", {31'h0, ledrst_ind}, {31'h0, m_ind});
    ledcs = 1'b0; ledwrite = 1'b0; ledread = 1'b0; ledaddr = 2'd0; ledwdata = 32'h0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] w);
    step(1'b1, 1'b1, 1'b0, a, w);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0000A5A5, 16'hA5A5, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h000000FF, 16'h00FF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd3, 32'h00000F0F, 16'h0FF0, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 16'h0FF0, 32'h00000FF0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h00001234, 16'h0FF0, 32'h00000FF0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'd0, 32'h00003C3C, 16'h3C3C, 32'h00000FF0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'd3, 32'h00000000, 16'h3C3C, 32'h00003C3C, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd1, 32'hFFFF0001, 16'h3C3C, 32'h00003C3C, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h00000000, 16'h3C3C, 32'h00000001, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd0, 32'hFFFFFFFF, 16'hFFFF, 32'h00000001, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 2'd2, 32'h00000000, 16'hFFFF, 32'h00000000, 1'b0};

    ledcs = 1'b0; ledwrite = 1'b0; ledread = 1'b0; ledaddr = 2'd0; ledwdata = 32'h0;
    ledrst = 1'b1;
    m_reset();
    #3;
    chk("reset_ledout", {16'h0, ledout}, 32'h0);
    chk("reset_ind", {31'h0, ledrst_ind}, 32'h1);
    chk("reset_rdata", ledrdata, 32'h0);
    @(posedge clk); @(posedge clk);
    ledrst = 1'b0;

    // T1/T2/T5 directed vectors
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].cs, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_ledout", i), {16'h0, ledout}, {16'h0, vecs[i].led});
      chk($sformatf("vec%0d_rdata", i), ledrdata, vecs[i].rdata);
      chk($sformatf("vec%0d_ind", i), {31'h0, ledrst_ind}, {31'h0, vecs[i].ind});
    end

    // Narrow instance ignores upper write bits and zero-extends readback
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
    chk("n8_ledout", {24'h0, ledout8}, 32'h000000FF);
    chk("n8_rdata", ledrdata8, 32'h000000FF);

    // T3 blink with DIV=4
    wr(2'd0, 32'h0000FFFF);
    wr(2'd1, 32'h0000000F);
    wr(2'd2, 32'd4);
    chk("t3_start", {16'h0, ledout}, 32'h0000FFFF);
    for (int k = 1; k <= 16; k++) begin
      idle();
      chk($sformatf("t3_k%0d", k), {16'h0, ledout},
          (((k / 4) % 2) == 0) ? 32'h0000FFFF : 32'h0000FFF0);
    end
    wr(2'd2, 32'd0);
    for (int k = 0; k < 5; k++) begin
      idle();
      chk("t3_frozen", {16'h0, ledout}, 32'h0000FFFF);
    end

    // T4 divider shrink restarts the count
    wr(2'd2, 32'd10);
    for (int k = 0; k < 8; k++) idle();
    chk("t4_before", {16'h0, ledout}, 32'h0000FFFF);
    wr(2'd2, 32'd3);
    idle();
    chk("t4_e1", {16'h0, ledout}, 32'h0000FFFF);
    idle();
    chk("t4_e2", {16'h0, ledout}, 32'h0000FFFF);
    idle();
    chk("t4_e3_flip", {16'h0, ledout}, 32'h0000FFF0);

    // T6 async reset mid-blink
    wr(2'd2, 32'd2);
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
    idle(); idle();
    chk("t6_dark", {16'h0, ledout}, 32'h0000FFF0);
    @(posedge clk);
    #2;
    ledrst = 1'b1;
    #1;
    m_reset();
    chk("t6_rst_ledout", {16'h0, ledout}, 32'h0);
    chk("t6_rst_ind", {31'h0, ledrst_ind}, 32'h1);
    chk("t6_rst_rdata", ledrdata, 32'h0);
    @(posedge clk);
    ledrst = 1'b0;
    wr(2'd0, 32'h0000FFFF);
    wr(2'd1, 32'h0000000F);
    chk("t6_lit_frozen", {16'h0, ledout}, 32'h0000FFFF);
    wr(2'd2, 32'd2);
    idle();
    chk("t6_lit_e1", {16'h0, ledout}, 32'h0000FFFF);
    idle();
    chk("t6_dark_e2", {16'h0, ledout}, 32'h0000FFF0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic        cs, we, re;
      logic [1:0]  a;
      logic [31:0] w;
      cs = ($urandom_range(0, 7) != 0);
      we = $urandom_range(0, 1);
      re = $urandom_range(0, 1);
      a  = 2'($urandom_range(0, 3));
      w  = (a == 2'd2) ? 32'($urandom_range(0, 6)) : $urandom;
      step(cs, we, re, a, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
